boom_trace_trig_ctrl: RTL and testbench

Trigger and sequencing controller for the BOOM instruction trace buffer. Watches the core trace interface and drives the trace unit's enable, so capture starts or stops around a programmable instruction-address trigger. Register-file settings come in; status, the trigger pointer and a done interrupt go out. Sits between the regfile and the trace buffer in the BOOM tile.

---
 rtl/boom_trace_trig_ctrl.sv | 129 ++++++++++++
 tb/tb_boom_trace_trig_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/boom_trace_trig_ctrl.sv
// Trigger/sequencing controller that gates the BOOM trace unit around an instruction-address trigger.
// Optional: define BOOM_TRACE_EXC_TRIG_EN to also trigger on any valid trace entry flagged as an exception.
module boom_trace_trig_ctrl #(
  parameter int ADDR_SIZE = 32,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 ctrl_start_i,
  input  logic                 ctrl_stop_i,
  input  logic                 ctrl_mode_i,
  input  logic [ADDR_SIZE-1:0] trig_addr_i,
  input  logic [ADDR_SIZE-1:0] trig_mask_i,
  input  logic [CNT_SIZE-1:0]  post_count_i,
  input  logic                 trace_valid,
  input  logic [39:0]          trace_iaddr,
  input  logic                 trace_exception,
  input  logic [ADDR_SIZE-1:0] trace_ptr_i,
  output logic                 trace_enabled_o,
  output logic [1:0]           state_o,
  output logic                 trig_hit_o,
  output logic [ADDR_SIZE-1:0] trig_ptr_o,
  output logic                 done_irq_o
);

  localparam int CMP_W = (ADDR_SIZE < 32) ? ADDR_SIZE : 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e              state;
  logic                en_q;
  logic                ptr_pend;
  logic [CNT_SIZE-1:0] cnt;
  logic [CNT_SIZE-1:0] cnt_inc;
  logic                addr_hit;
  logic                hit;
  logic                last;
  logic                unused_bits;

  assign addr_hit = trace_valid &&
    (((trace_iaddr[CMP_W-1:0] ^ trig_addr_i[CMP_W-1:0]) & trig_mask_i[CMP_W-1:0]) == '0);

`ifdef BOOM_TRACE_EXC_TRIG_EN
  assign hit         = addr_hit || (trace_valid && trace_exception);
  assign unused_bits = ^trace_iaddr[39:CMP_W];
`else
  assign hit         = addr_hit;
  assign unused_bits = ^{trace_iaddr[39:CMP_W], trace_exception};
`endif

  // Saturating count; post_count_i of zero means capture never self-terminates.
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_SIZE'(1);
  assign last    = (post_count_i != '0) && (cnt_inc == post_count_i);

  // Start-on-trigger must capture the trigger entry itself, so the enable is combinational there.
  assign trace_enabled_o = (state == ARMED && !ctrl_mode_i) ? hit : en_q;
  assign state_o         = state;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      en_q       <= 1'b0;
      ptr_pend   <= 1'b0;
      cnt        <= '0;
      trig_hit_o <= 1'b0;
      trig_ptr_o <= '0;
      done_irq_o <= 1'b0;
    end else begin
      done_irq_o <= 1'b0;
      // The trace unit exposes the trigger entry's write address one cycle after the hit.
      if (ptr_pend) begin
        trig_ptr_o <= trace_ptr_i;
        ptr_pend   <= 1'b0;
      end
      case (state)
        IDLE, DONE: begin
          if (ctrl_start_i && !ctrl_stop_i) begin
            state      <= ARMED;
            en_q       <= ctrl_mode_i;
            trig_hit_o <= 1'b0;
            trig_ptr_o <= '0;
            ptr_pend   <= 1'b0;
            cnt        <= '0;
          end
        end
        ARMED: begin
          if (ctrl_stop_i) begin
            state <= IDLE;
            en_q  <= 1'b0;
          end else if (hit) begin
            trig_hit_o <= 1'b1;
            ptr_pend   <= 1'b1;
            cnt        <= CNT_SIZE'(1);
            if (post_count_i == CNT_SIZE'(1)) begin
              state      <= DONE;
              en_q       <= 1'b0;
              done_irq_o <= 1'b1;
            end else begin
              state <= CAPTURE;
              en_q  <= 1'b1;
            end
          end else begin
            en_q <= ctrl_mode_i;
          end
        end
        CAPTURE: begin
          if (ctrl_stop_i) begin
            state      <= DONE;
            en_q       <= 1'b0;
            done_irq_o <= 1'b1;
          end else if (trace_valid) begin
            cnt <= cnt_inc;
            if (last) begin
              state      <= DONE;
              en_q       <= 1'b0;
              done_irq_o <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boom_trace_trig_ctrl.sv
// Scoreboard bench for boom_trace_trig_ctrl: drivers push per-cycle expectations, a negedge monitor checks them.
module tb_boom_trace_trig_ctrl;

  localparam int W = 37;
`ifdef BOOM_TRACE_EXC_TRIG_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        ctrl_start_i = 1'b0;
  logic        ctrl_stop_i = 1'b0;
  logic        ctrl_mode_i = 1'b0;
  logic [31:0] trig_addr_i = '0;
  logic [31:0] trig_mask_i = '0;
  logic [15:0] post_count_i = '0;
  logic        trace_valid = 1'b0;
  logic [39:0] trace_iaddr = '0;
  logic        trace_exception = 1'b0;
  logic [31:0] trace_ptr_i = '0;
  logic        trace_enabled_o;
  logic [1:0]  state_o;
  logic        trig_hit_o;
  logic [31:0] trig_ptr_o;
  logic        done_irq_o;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic [W-1:0] mon_e;
  string        mon_t;
  int           checks = 0;
  int           errors = 0;

  boom_trace_trig_ctrl #(.ADDR_SIZE(32), .CNT_SIZE(16)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .ctrl_start_i   (ctrl_start_i),
    .ctrl_stop_i    (ctrl_stop_i),
    .ctrl_mode_i    (ctrl_mode_i),
    .trig_addr_i    (trig_addr_i),
    .trig_mask_i    (trig_mask_i),
    .post_count_i   (post_count_i),
    .trace_valid    (trace_valid),
    .trace_iaddr    (trace_iaddr),
    .trace_exception(trace_exception),
    .trace_ptr_i    (trace_ptr_i),
    .trace_enabled_o(trace_enabled_o),
    .state_o        (state_o),
    .trig_hit_o     (trig_hit_o),
    .trig_ptr_o     (trig_ptr_o),
    .done_irq_o     (done_irq_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input logic mode, input logic [31:0] addr, input logic [31:0] mask,
                         input logic [15:0] post);
    ctrl_mode_i  = mode;
    trig_addr_i  = addr;
    trig_mask_i  = mask;
    post_count_i = post;
  endtask

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic cyc(input string name, input logic st, input logic sp, input logic v,
                     input logic [39:0] ia, input logic exc, input logic [31:0] p,
                     input logic e_en, input logic [1:0] e_st, input logic e_hit,
                     input logic e_irq, input logic [31:0] e_ptr);
    @(posedge clk_i);
    #1;
    ctrl_start_i    = st;
    ctrl_stop_i     = sp;
    trace_valid     = v;
    trace_iaddr     = ia;
    trace_exception = exc;
    trace_ptr_i     = p;
    exp_q.push_back({e_en, e_st, e_hit, e_irq, e_ptr});
    tag_q.push_back(name);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(negedge clk_i);
      #2;
      n++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      cmp({mon_t, ".en"},    32'(trace_enabled_o), 32'(mon_e[36]));
      cmp({mon_t, ".state"}, 32'(state_o),         32'(mon_e[35:34]));
      cmp({mon_t, ".hit"},   32'(trig_hit_o),      32'(mon_e[33]));
      cmp({mon_t, ".irq"},   32'(done_irq_o),      32'(mon_e[32]));
      cmp({mon_t, ".ptr"},   trig_ptr_o,           mon_e[31:0]);
    end
  end

  initial begin
    #12;
    cmp("rst.en", 32'(trace_enabled_o), 0);
    cmp("rst.state", 32'(state_o), 0);
    cmp("rst.hit", 32'(trig_hit_o), 0);
    cmp("rst.irq", 32'(done_irq_o), 0);
    cmp("rst.ptr", trig_ptr_o, 0);
    @(posedge clk_i);
    #2;
    reset_n_i = 1'b1;

    // Start-on-trigger, post_count 3
    set_cfg(1'b0, 32'h8000_1000, 32'hFFFF_FFFF, 16'd3);
    cyc("m0c0", 1, 0, 0, 40'h0,           0, 32'h0,  0, 2'd0, 0, 0, 32'h0);
    cyc("m0c1", 0, 0, 1, 40'h8000_0FFC,   0, 32'h0,  0, 2'd1, 0, 0, 32'h0);
    cyc("m0c2", 0, 0, 1, 40'h8000_1000,   0, 32'h0,  1, 2'd1, 0, 0, 32'h0);
    cyc("m0c3", 0, 0, 1, 40'h8000_1004,   0, 32'h20, 1, 2'd2, 1, 0, 32'h0);
    cyc("m0c4", 0, 0, 1, 40'h8000_1008,   0, 32'h21, 1, 2'd2, 1, 0, 32'h20);
    cyc("m0c5", 0, 0, 1, 40'h8000_100C,   0, 32'h0,  0, 2'd3, 1, 1, 32'h20);
    cyc("m0c6", 0, 0, 0, 40'h0,           0, 32'h0,  0, 2'd3, 1, 0, 32'h20);

    // Center-trigger, post_count 2, pointer tracks written entries
    set_cfg(1'b1, 32'h8000_2000, 32'hFFFF_FFFF, 16'd2);
    cyc("m1c0", 1, 0, 0, 40'h0,           0, 32'd0, 0, 2'd3, 1, 0, 32'h20);
    cyc("m1c1", 0, 0, 1, 40'h100,         0, 32'd0, 1, 2'd1, 0, 0, 32'h0);
    cyc("m1c2", 0, 0, 1, 40'h104,         0, 32'd0, 1, 2'd1, 0, 0, 32'h0);
    cyc("m1c3", 0, 0, 1, 40'h108,         0, 32'd1, 1, 2'd1, 0, 0, 32'h0);
    cyc("m1c4", 0, 0, 1, 40'h10C,         0, 32'd2, 1, 2'd1, 0, 0, 32'h0);
    cyc("m1c5", 0, 0, 1, 40'h110,         0, 32'd3, 1, 2'd1, 0, 0, 32'h0);
    cyc("m1c6", 0, 0, 1, 40'h8000_2000,   0, 32'd4, 1, 2'd1, 0, 0, 32'h0);
    cyc("m1c7", 0, 0, 1, 40'h8000_2004,   0, 32'd5, 1, 2'd2, 1, 0, 32'h0);
    cyc("m1c8", 0, 0, 0, 40'h0,           0, 32'd6, 0, 2'd3, 1, 1, 32'd5);
    cyc("m1c9", 0, 0, 0, 40'h0,           0, 32'd6, 0, 2'd3, 1, 0, 32'd5);

    // Unlimited capture, then stop
    set_cfg(1'b0, 32'h8000_3000, 32'hFFFF_FFFF, 16'd0);
    cyc("unl0", 1, 0, 0, 40'h0,           0, 32'h0,  0, 2'd3, 1, 0, 32'd5);
    cyc("unl1", 0, 0, 1, 40'h8000_3000,   0, 32'h0,  1, 2'd1, 0, 0, 32'h0);
    cyc("unl2", 0, 0, 1, 40'h0,           0, 32'h40, 1, 2'd2, 1, 0, 32'h0);
    for (int i = 0; i < 100; i++)
      cyc("unlv", 0, 0, 1, 40'(i * 4), 0, 32'(i), 1, 2'd2, 1, 0, 32'h40);
    cyc("unl3", 0, 1, 0, 40'h0,           0, 32'h0,  1, 2'd2, 1, 0, 32'h40);
    cyc("unl4", 0, 0, 0, 40'h0,           0, 32'h0,  0, 2'd3, 1, 1, 32'h40);
    cyc("unl5", 0, 0, 0, 40'h0,           0, 32'h0,  0, 2'd3, 1, 0, 32'h40);

    // Stop while armed, stop colliding with a hit
    cyc("stp0", 1, 0, 0, 40'h0,           0, 32'h0,  0, 2'd3, 1, 0, 32'h40);
    cyc("stp1", 0, 1, 0, 40'h0,           0, 32'h0,  0, 2'd1, 0, 0, 32'h0);
    cyc("stp2", 0, 0, 0, 40'h0,           0, 32'h0,  0, 2'd0, 0, 0, 32'h0);
    cyc("stp3", 0, 0, 0, 40'h0,           0, 32'h0,  0, 2'd0, 0, 0, 32'h0);
    cyc("sth0", 1, 0, 0, 40'h0,           0, 32'h0,  0, 2'd0, 0, 0, 32'h0);
    cyc("sth1", 0, 1, 1, 40'h8000_3000,   0, 32'h0,  1, 2'd1, 0, 0, 32'h0);
    cyc("sth2", 0, 0, 0, 40'h0,           0, 32'h0,  0, 2'd0, 0, 0, 32'h0);

    // post_count 1, then start+stop together in DONE
    set_cfg(1'b0, 32'h8000_3000, 32'hFFFF_FFFF, 16'd1);
    cyc("pc1a", 1, 0, 0, 40'h0,           0, 32'h0,  0, 2'd0, 0, 0, 32'h0);
    cyc("pc1b", 0, 0, 1, 40'h8000_3000,   0, 32'h0,  1, 2'd1, 0, 0, 32'h0);
    cyc("pc1c", 0, 0, 1, 40'h8000_3004,   0, 32'h55, 0, 2'd3, 1, 1, 32'h0);
    cyc("pc1d", 1, 1, 0, 40'h0,           0, 32'h0,  0, 2'd3, 1, 0, 32'h55);
    cyc("pc1e", 0, 0, 0, 40'h0,           0, 32'h0,  0, 2'd3, 1, 0, 32'h55);

    // Partial mask
    set_cfg(1'b0, 32'h8000_1000, 32'hFFFF_F000, 16'd0);
    cyc("msk0", 1, 0, 0, 40'h0,           0, 32'h0,  0, 2'd3, 1, 0, 32'h55);
    cyc("msk1", 0, 0, 1, 40'h8000_1FFC,   0, 32'h0,  1, 2'd1, 0, 0, 32'h0);
    cyc("msk2", 0, 0, 0, 40'h0,           0, 32'h7,  1, 2'd2, 1, 0, 32'h0);
    cyc("msk3", 0, 1, 0, 40'h0,           0, 32'h0,  1, 2'd2, 1, 0, 32'h7);
    cyc("msk4", 0, 0, 0, 40'h0,           0, 32'h0,  0, 2'd3, 1, 1, 32'h7);

    // Exception at a non-matching address
    set_cfg(1'b0, 32'h8000_1000, 32'hFFFF_FFFF, 16'd0);
    cyc("exc0", 1, 0, 0, 40'h0,  0, 32'h0, 0,      2'd3, 1, 0, 32'h7);
    cyc("exc1", 0, 0, 1, 40'h10, 1, 32'h0, EXC_EN, 2'd1, 0, 0, 32'h0);
    cyc("exc2", 0, 0, 0, 40'h0,  0, 32'h0, EXC_EN, EXC_EN ? 2'd2 : 2'd1, EXC_EN, 0, 32'h0);
    cyc("exc3", 0, 1, 0, 40'h0,  0, 32'h0, EXC_EN, EXC_EN ? 2'd2 : 2'd1, EXC_EN, 0, 32'h0);
    cyc("exc4", 0, 0, 0, 40'h0,  0, 32'h0, 0,      EXC_EN ? 2'd3 : 2'd0, EXC_EN, EXC_EN, 32'h0);

    // Asynchronous reset during capture
    set_cfg(1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 16'd0);
    cyc("rsc0", 1, 0, 0, 40'h0,         0, 32'h0, 0, EXC_EN ? 2'd3 : 2'd0, EXC_EN, 0, 32'h0);
    cyc("rsc1", 0, 0, 1, 40'h8000_1000, 0, 32'h0, 1, 2'd1, 0, 0, 32'h0);
    cyc("rsc2", 0, 0, 0, 40'h0,         0, 32'h9, 1, 2'd2, 1, 0, 32'h0);
    cyc("rsc3", 0, 0, 0, 40'h0,         0, 32'h0, 1, 2'd2, 1, 0, 32'h9);
    drain();
    reset_n_i = 1'b0;
    #1;
    cmp("arst.en", 32'(trace_enabled_o), 0);
    cmp("arst.state", 32'(state_o), 0);
    cmp("arst.hit", 32'(trig_hit_o), 0);
    cmp("arst.irq", 32'(done_irq_o), 0);
    cmp("arst.ptr", trig_ptr_o, 0);
    @(posedge clk_i);
    #2;
    reset_n_i = 1'b1;

    set_cfg(1'b0, 32'h8000_1000, 32'hFFFF_FFFF, 16'd3);
    cyc("rea0", 1, 0, 0, 40'h0,         0, 32'h0, 0, 2'd0, 0, 0, 32'h0);
    cyc("rea1", 0, 0, 1, 40'h8000_1000, 0, 32'h0, 1, 2'd1, 0, 0, 32'h0);
    cyc("rea2", 0, 0, 0, 40'h0,         0, 32'h0, 1, 2'd2, 1, 0, 32'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
